// File: rtl/alu_muldiv_control_if.sv
// rtl/alu_muldiv_control_if.sv - execute-stage ALU/mul-div control bus
// Purpose: groups the decode inputs, operands and result/stall outputs of
//   alu_muldiv_control into one bundle.
// Ports (signals): alu_op, funct7, funct3, valid, flush, rs1_val, rs2_val
//   (pipeline -> block); alu_func, md_sel, md_result, stall, md_done
//   (block -> pipeline).
// Modports: master = pipeline side, slave = alu_muldiv_control side.
interface alu_muldiv_control_if #(
  parameter int XLEN = 32
) ();
  logic [1:0]      alu_op;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic            valid;
  logic            flush;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [3:0]      alu_func;
  logic            md_sel;
  logic [XLEN-1:0] md_result;
  logic            stall;
  logic            md_done;

  modport master (
    output alu_op, funct7, funct3, valid, flush, rs1_val, rs2_val,
    input  alu_func, md_sel, md_result, stall, md_done
  );

  modport slave (
    input  alu_op, funct7, funct3, valid, flush, rs1_val, rs2_val,
    output alu_func, md_sel, md_result, stall, md_done
  );
endinterface

// File: rtl/alu_muldiv_control.sv
// rtl/alu_muldiv_control.sv - execute-stage ALU decode plus iterative RV32M multiply/divide
// Purpose: decodes alu_op/funct7/funct3 into alu_func for the base integer
//   classes and runs M-extension ops on a shift-add multiplier / restoring
//   divider, stalling the pipeline until the result is presented.
// Ports: clk, reset (asynchronous, active-high);
//   bus (alu_muldiv_control_if.slave):
//     in  alu_op, funct7, funct3, valid, flush, rs1_val, rs2_val
//     out alu_func, md_sel, md_result, stall, md_done
// Config: define ALU_MULDIV_FAST_MUL_EN to compute all multiplies in a single
//   registered cycle (divides stay iterative).
module alu_muldiv_control #(
  parameter int XLEN = 32
) (
  input logic                 clk,
  input logic                 reset,
  alu_muldiv_control_if.slave bus
);
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_BGE  = 4'b1010;
  localparam logic [3:0] ALU_BGEU = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_EEE  = 4'b1111;

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic            neg_q;    // negate product / quotient
  logic            rneg_q;   // negate remainder (dividend was negative)
  logic [XLEN-1:0] opnd_q;   // multiplicand (mul) or divisor (div) magnitude
  logic [XLEN-1:0] acc_q;    // product high half / partial remainder
  logic [XLEN-1:0] quo_q;    // multiplier shifting out / quotient shifting in
  logic [XLEN-1:0] md_result_q;
  logic            md_done_q;

  logic is_m;
  assign is_m = (bus.alu_op == 2'b10) && (bus.funct7 == 7'b0000001);

  // Base decode
  always_comb begin
    bus.alu_func = ALU_EEE;
    unique case (bus.alu_op)
      2'b00: bus.alu_func = ALU_ADD;
      2'b01: begin
        unique case (bus.funct3)
          3'b000:  bus.alu_func = ALU_XOR;
          3'b001:  bus.alu_func = ALU_SUB;
          3'b100:  bus.alu_func = ALU_SLT;
          3'b101:  bus.alu_func = ALU_BGE;
          3'b110:  bus.alu_func = ALU_SLTU;
          3'b111:  bus.alu_func = ALU_BGEU;
          default: bus.alu_func = ALU_EEE;
        endcase
      end
      2'b10: begin
        if (is_m) begin
          bus.alu_func = ALU_ADD;
        end else begin
          unique case ({bus.funct7[5], bus.funct3})
            4'b0000: bus.alu_func = ALU_ADD;
            4'b1000: bus.alu_func = ALU_SUB;
            4'b0001: bus.alu_func = ALU_SLL;
            4'b0010: bus.alu_func = ALU_SLT;
            4'b0011: bus.alu_func = ALU_SLTU;
            4'b0100: bus.alu_func = ALU_XOR;
            4'b0101: bus.alu_func = ALU_SRL;
            4'b1101: bus.alu_func = ALU_SRA;
            4'b0110: bus.alu_func = ALU_OR;
            4'b0111: bus.alu_func = ALU_AND;
            default: bus.alu_func = ALU_EEE;
          endcase
        end
      end
      default: begin
        unique case (bus.funct3)
          3'b000:  bus.alu_func = ALU_ADD;
          3'b001:  bus.alu_func = ALU_SLL;
          3'b010:  bus.alu_func = ALU_SLT;
          3'b011:  bus.alu_func = ALU_SLTU;
          3'b100:  bus.alu_func = ALU_XOR;
          3'b101:  bus.alu_func = bus.funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  bus.alu_func = ALU_OR;
          default: bus.alu_func = ALU_AND;
        endcase
      end
    endcase
  end

  assign bus.md_sel    = is_m;
  assign bus.stall     = bus.valid && is_m && (state_q != DONE);
  assign bus.md_result = md_result_q;
  assign bus.md_done   = md_done_q;

  // Accept-time operand preparation. rs1 is signed for mul/mulh/mulhsu/div/rem,
  // rs2 only for mul/mulh/div/rem; mulhsu therefore gets neg = rs1 sign alone.
  logic            a_sgn, b_sgn, s1, s2, neg_d, dz, ovf;
  logic [XLEN-1:0] mag1, mag2, special_res;
  always_comb begin
    a_sgn = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b101) && (bus.funct3 != 3'b111);
    b_sgn = a_sgn && (bus.funct3 != 3'b010);
    s1    = a_sgn && bus.rs1_val[XLEN-1];
    s2    = b_sgn && bus.rs2_val[XLEN-1];
    neg_d = s1 ^ s2;
    mag1  = s1 ? -bus.rs1_val : bus.rs1_val;
    mag2  = s2 ? -bus.rs2_val : bus.rs2_val;
    dz    = bus.funct3[2] && (bus.rs2_val == '0);
    ovf   = bus.funct3[2] && !bus.funct3[0] && (bus.rs1_val == SMIN) && (bus.rs2_val == '1);
    // funct3[1] separates rem/remu from div/divu
    if (dz) special_res = bus.funct3[1] ? bus.rs1_val : '1;
    else    special_res = bus.funct3[1] ? '0 : bus.rs1_val;
  end

`ifdef ALU_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_p, fast_ps;
  logic [XLEN-1:0]   fast_res;
  always_comb begin
    fast_p   = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
    fast_ps  = neg_d ? -fast_p : fast_p;
    fast_res = (bus.funct3[1:0] == 2'b00) ? fast_ps[XLEN-1:0] : fast_ps[2*XLEN-1:XLEN];
  end
`endif

  // One engine iteration plus the final sign fix applied to that iteration's output.
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_trial, acc_n, quo_n, fin_res;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_s;
  always_comb begin
    mul_sum   = {1'b0, acc_q} + ({1'b0, opnd_q} & {(XLEN+1){quo_q[0]}});
    div_shift = {acc_q, quo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    // Partial remainder stays below the divisor, so the XLEN-bit difference is exact.
    div_trial = div_shift[XLEN-1:0] - opnd_q;
    if (op_q[2]) begin
      acc_n = div_ge ? div_trial : div_shift[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], div_ge};
    end else begin
      acc_n = mul_sum[XLEN:1];
      quo_n = {mul_sum[0], quo_q[XLEN-1:1]};
    end
    prod_s = neg_q ? -{acc_n, quo_n} : {acc_n, quo_n};
    if (!op_q[2])    fin_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else if (op_q[1]) fin_res = rneg_q ? -acc_n : acc_n;
    else             fin_res = neg_q ? -quo_n : quo_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      opnd_q      <= '0;
      acc_q       <= '0;
      quo_q       <= '0;
      md_result_q <= '0;
      md_done_q   <= 1'b0;
    end else begin
      md_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.valid && is_m && !bus.flush) begin
            op_q   <= bus.funct3;
            neg_q  <= neg_d;
            rneg_q <= s1;
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= bus.funct3[2] ? mag2 : mag1;
            quo_q  <= bus.funct3[2] ? mag1 : mag2;
            if (dz || ovf) begin
              md_result_q <= special_res;
              md_done_q   <= 1'b1;
              state_q     <= DONE;
            end
`ifdef ALU_MULDIV_FAST_MUL_EN
            else if (!bus.funct3[2]) begin
              md_result_q <= fast_res;
              md_done_q   <= 1'b1;
              state_q     <= DONE;
            end
`endif
            else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN-1)) begin
              md_result_q <= fin_res;
              md_done_q   <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_muldiv_control.md
# alu_muldiv_control

Next-generation execute-stage ALU controller, parametrised by datapath width XLEN. Decodes ALUOp/funct7/funct3 into the 4-bit `alu_func` for all base RV32I classes: loads/stores, branches, R-type and I-type. Also recognises RV32M R-type instructions (funct7 = 7'b0000001) and executes them on an internal iterative multiply/divide engine. While that engine runs, the block stalls the pipeline and then presents the result.

## Interface
- `XLEN`, default 32: operand/result width; any even value ≥ 8.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `alu_op`  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type immediate.
- `funct7`  in  7  instruction funct7.
- `funct3`  in  3  instruction funct3.
- `valid`  in  1  a real instruction occupies EX this cycle.
- `flush`  in  1  kill the instruction in EX.
- `rs1_val`  in  XLEN  operand A.
- `rs2_val`  in  XLEN  operand B.
- `alu_func`  out  4  ALU operation code from the shared defines header.
- `md_sel`  out  1  writeback takes `md_result` instead of the ALU output.
- `md_result`  out  XLEN  M-extension result.
- `stall`  out  1  hold IF/ID/EX and EX inputs stable.
- `md_done`  out  1  one-cycle pulse when `md_result` is valid.

## Operation
- `alu_func` is combinational and matches the established base decode:
  - 00 → ADD.
  - 01 → beq XOR, bne SUB, blt SLT, bge BGE, bltu SLTU, bgeu BGEU.
  - 10 → {funct7[5], funct3} table.
  - 11 → I-type; funct3 = 101 splits SRL/SRA on funct7[5].
  - Unlisted codes → EEE.
- `is_m = (alu_op == 10) && (funct7 == 7'b0000001)`. When set, `alu_func` = ADD (don't-care) and `md_sel` = 1.
- M-op selection by funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- FSM states IDLE, BUSY, DONE.
  - IDLE → BUSY on `valid && is_m && !flush`. Latches operand magnitudes, sign flags and op; counter = 0.
  - IDLE → DONE directly for the special divide cases below.
  - BUSY: one iteration per cycle, counter increments; → DONE when counter = XLEN-1.
  - DONE: `md_result` valid, `md_done` = 1; → IDLE unconditionally.
- Multiply engine:
  - Shift-add on magnitudes, 2·XLEN-bit product.
  - Final sign fix: mul/mulh negate if signs differ; mulhsu uses only rs1's sign; mulhu unsigned.
  - mul returns low XLEN bits; the other multiplies return high XLEN bits.
- Divide engine: restoring, one quotient bit per cycle on magnitudes.
  - Quotient negated if signs differ (signed ops).
  - Remainder takes the dividend's sign.
- Special divide cases, one-cycle path IDLE → DONE:
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (rs1 = 1<<(XLEN-1), rs2 = all ones): quotient = rs1; remainder = 0.
- `stall = valid && is_m && (state != DONE)`. It is asserted combinationally in the accept cycle.
- `flush` in any state → IDLE next edge; no `md_done`; `md_result` unchanged.

## Timing
- Reset values: state IDLE, `md_result` = 0, `md_done` = 0, counter = 0.
  - `stall` and `md_sel` follow inputs combinationally; `stall` is 0 when `valid` = 0.
- Normal M op, accept at cycle 0:
  - BUSY during cycles 1..XLEN; DONE at cycle XLEN+1.
  - `stall` high for cycles 0..XLEN, i.e. XLEN+1 cycles; the pipeline advances at the end of cycle XLEN+1.
- Special divide case: `stall` high in cycle 0 only; DONE in cycle 1.
- Back-to-back M ops: the second instruction reaches EX in the cycle after DONE and is accepted in IDLE (no bubble beyond the FSM).
- Reset asserted mid-operation: immediate return to reset values; partial results discarded.
- `flush` and DONE in the same cycle: the flush wins; `md_done` is still 1 that cycle, and the pipeline discards it.

## Configuration
- `ALU_MULDIV_FAST_MUL_EN` defined:
  - All four multiplies compute with a single-cycle XLEN×XLEN multiply, registered.
  - Path is IDLE → DONE; `stall` high 1 cycle.
  - Divides remain iterative.
- Undefined: multiplies use the iterative engine (XLEN+1 stall cycles).

## Test plan
- Base decode sweep: alu_op 11, funct3 101, funct7 0x20 → SRA. alu_op 01, funct3 010 → EEE. `stall` = 0 throughout.
- mul 7 × 0xFFFFFFFD (XLEN 32, iterative) → `stall` 33 cycles, then `md_result` = 0xFFFFFFEB with `md_done` = 1 for one cycle. mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- div 0x80000000 / 0xFFFFFFFF → 0x80000000 after 1 stall cycle. rem on the same operands → 0.
- divu 10 / 0 → 0xFFFFFFFF; remu 10 / 0 → 10. rem −7 / 2 → 0xFFFFFFFF; div −7 / 2 → 0xFFFFFFFD.
- `flush` asserted at BUSY cycle 5 → IDLE next edge, no `md_done`. A following mul 3 × 4 returns 12.
- `reset` pulsed at BUSY cycle 10 → all outputs at reset values in the same cycle. With the fast-multiply macro defined, mul 3 × 4 → 12 with 1 stall cycle.
